// File: rtl/bitserial_subtractor.sv
// Bit-serial 4-bit subtractor: LED = {borrow, A - B - BIN}, plus a seven-segment view of the result.
// Latency: START sampled at edge N, bits processed at N+1..N+4, result and DONE visible after N+4.
// Backpressure: none; START is ignored while BUSY, and a held START restarts every 5 cycles.
//
// Ports:
//   CLK          system clock, rising edge
//   RSTN         asynchronous active-low reset
//   SW[7:0]      {B, A} operands, unsigned 4-bit each
//   BIN          borrow-in
//   START        level-sampled request, honoured only in IDLE
//   FLIP         display select: 0 = difference bits, 1 = borrow-out
//   LED[4:0]     {last borrow-out, last difference}
//   BUSY         high while shifting
//   DONE         one-cycle pulse after a new result is loaded
//   SLED0..SLED4 active-low seven-segment codes {a,b,c,d,e,f,g}
module bitserial_subtractor (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] SW,
    input  logic       BIN,
    input  logic       START,
    input  logic       FLIP,
    output logic [4:0] LED,
    output logic       BUSY,
    output logic       DONE,
    output logic [6:0] SLED0,
    output logic [6:0] SLED1,
    output logic [6:0] SLED2,
    output logic [6:0] SLED3,
    output logic [6:0] SLED4
);

    localparam logic [6:0] SEG_ZERO  = 7'b0000001;
    localparam logic [6:0] SEG_ONE   = 7'b1001111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_B     = 7'b1100000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_load;
    logic       w_last;

    logic [1:0] r_cnt;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_br;
    logic [3:0] r_d;
    logic [4:0] r_led;
    logic       r_done;

    logic       w_dbit;
    logic       w_br_nxt;
    logic [3:0] w_d_nxt;

    // Full-subtractor cell on the current LSBs.
    assign w_dbit   = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    // Difference bits enter at the top so after four shifts bit 0 sits at r_d[0].
    assign w_d_nxt  = {w_dbit, r_d[3:1]};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == 2'd3) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt  <= 2'd0;
            r_a    <= 4'd0;
            r_b    <= 4'd0;
            r_br   <= 1'b0;
            r_d    <= 4'd0;
            r_led  <= 5'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                // Operands are captured here so later SW/BIN changes cannot disturb the run.
                r_a   <= SW[3:0];
                r_b   <= SW[7:4];
                r_br  <= BIN;
                r_cnt <= 2'd0;
            end else if (r_state == ST_SHIFT) begin
                r_a   <= {1'b0, r_a[3:1]};
                r_b   <= {1'b0, r_b[3:1]};
                r_br  <= w_br_nxt;
                r_d   <= w_d_nxt;
                r_cnt <= r_cnt + 2'd1;
                if (w_last) begin
                    r_led <= {w_br_nxt, w_d_nxt};
                end
            end
        end
    end

    assign LED  = r_led;
    assign BUSY = (r_state == ST_SHIFT);
    assign DONE = r_done;

    always_comb begin
        SLED0 = SEG_BLANK;
        SLED1 = SEG_BLANK;
        SLED2 = SEG_BLANK;
        SLED3 = SEG_BLANK;
        SLED4 = SEG_BLANK;
        if (FLIP) begin
            SLED0 = r_led[4] ? SEG_ONE : SEG_ZERO;
            SLED4 = SEG_B;
        end else begin
            SLED0 = r_led[0] ? SEG_ONE : SEG_ZERO;
            SLED1 = r_led[1] ? SEG_ONE : SEG_ZERO;
            SLED2 = r_led[2] ? SEG_ONE : SEG_ZERO;
            SLED3 = r_led[3] ? SEG_ONE : SEG_ZERO;
            SLED4 = SEG_D;
        end
    end

endmodule

// File: tb/tb_bitserial_subtractor.sv
module tb_bitserial_subtractor;

    logic       CLK;
    logic       RSTN;
    logic [7:0] SW;
    logic       BIN;
    logic       START;
    logic       FLIP;
    logic [4:0] LED;
    logic       BUSY;
    logic       DONE;
    logic [6:0] SLED0, SLED1, SLED2, SLED3, SLED4;

    int n_pass  = 0;
    int n_total = 0;

    bitserial_subtractor dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .SW    (SW),
        .BIN   (BIN),
        .START (START),
        .FLIP  (FLIP),
        .LED   (LED),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SLED0 (SLED0),
        .SLED1 (SLED1),
        .SLED2 (SLED2),
        .SLED3 (SLED3),
        .SLED4 (SLED4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [4:0] ref_led(input int a, input int b, input int bin);
        int diff;
        diff = a - b - bin;
        ref_led = {(a < b + bin) ? 1'b1 : 1'b0, 4'(diff & 15)};
    endfunction

    function automatic logic [6:0] ref_digit(input logic v);
        ref_digit = v ? 7'b1001111 : 7'b0000001;
    endfunction

    task automatic chk_disp(input logic flip, input logic [4:0] led);
        FLIP = flip;
        #1;
        if (!flip) begin
            chk("sled0_d", SLED0, ref_digit(led[0]));
            chk("sled1_d", SLED1, ref_digit(led[1]));
            chk("sled2_d", SLED2, ref_digit(led[2]));
            chk("sled3_d", SLED3, ref_digit(led[3]));
            chk("sled4_d", SLED4, 7'b1000010);
        end else begin
            chk("sled0_b", SLED0, ref_digit(led[4]));
            chk("sled1_b", SLED1, 7'b1111111);
            chk("sled2_b", SLED2, 7'b1111111);
            chk("sled3_b", SLED3, 7'b1111111);
            chk("sled4_b", SLED4, 7'b1100000);
        end
    endtask

    // One START pulse, then cycle-accurate checks of BUSY/DONE/LED.
    task automatic run_op(input int a, input int b, input int bin);
        logic [4:0] exp_led;
        exp_led = ref_led(a, b, bin);
        @(negedge CLK);
        SW    = {4'(b), 4'(a)};
        BIN   = bin[0];
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("op_busy", BUSY, 1'b1);
            chk("op_nodone", DONE, 1'b0);
            @(negedge CLK);
        end
        chk("op_done", DONE, 1'b1);
        chk("op_busy_end", BUSY, 1'b0);
        chk("op_led", LED, exp_led);
        @(negedge CLK);
        chk("op_done_pulse", DONE, 1'b0);
        chk("op_led_hold", LED, exp_led);
    endtask

    initial begin
        int dones;
        logic [4:0] exp_led;
        int a, b, bin;

        RSTN = 1'b0; SW = 8'h00; BIN = 1'b0; START = 1'b0; FLIP = 1'b0;
        #2;
        chk("rst_led", LED, 5'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk_disp(1'b0, 5'd0);
        chk_disp(1'b1, 5'd0);
        FLIP = 1'b0;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;

        // Basic cases
        run_op(9, 3, 0);
        chk_disp(1'b0, 5'b00110);
        run_op(3, 9, 0);
        chk("led_3m9", LED, 5'b11010);
        chk_disp(1'b1, 5'b11010);
        chk_disp(1'b0, 5'b11010);
        run_op(0, 0, 1);
        chk("led_0m0m1", LED, 5'b11111);
        chk_disp(1'b0, 5'b11111);
        run_op(15, 15, 0);
        run_op(15, 0, 1);

        // START while busy ignored; operand changes after START ignored
        @(negedge CLK);
        SW = {4'd3, 4'd9}; BIN = 1'b0; START = 1'b1;
        @(negedge CLK);                       // after N
        START = 1'b0; SW = 8'hF0; BIN = 1'b1;
        @(negedge CLK);                       // after N+1
        START = 1'b1;
        @(negedge CLK);                       // after N+2
        START = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (DONE) dones++;
            @(negedge CLK);
        end
        chk("ign_dones", dones, 1);
        chk("ign_led", LED, 5'b00110);
        chk("ign_busy", BUSY, 1'b0);

        // Reset mid-operation
        run_op(2, 5, 1);                      // LED nonzero beforehand
        @(negedge CLK);
        SW = {4'd1, 4'd7}; BIN = 1'b0; START = 1'b1;
        @(negedge CLK);                       // after N
        START = 1'b0;
        @(negedge CLK);                       // after N+1
        RSTN = 1'b0;
        #1;
        chk("mid_rst_busy", BUSY, 1'b0);
        chk("mid_rst_led", LED, 5'd0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        chk("mid_rst_nodone", dones, 0);
        RSTN = 1'b1;
        run_op(7, 1, 0);

        // START held high: back-to-back random ops, 5-cycle period
        for (int k = 0; k < 200; k++) begin
            a   = int'($urandom_range(0, 15));
            b   = int'($urandom_range(0, 15));
            bin = int'($urandom_range(0, 1));
            exp_led = ref_led(a, b, bin);
            SW    = {4'(b), 4'(a)};
            BIN   = bin[0];
            START = 1'b1;
            @(negedge CLK);                   // after start edge
            chk("bb_busy", BUSY, 1'b1);
            SW  = 8'($urandom);
            BIN = 1'($urandom);
            FLIP = 1'($urandom);
            repeat (3) begin
                @(negedge CLK);
                chk("bb_nodone", DONE, 1'b0);
            end
            @(negedge CLK);                   // after start edge + 4
            chk("bb_done", DONE, 1'b1);
            chk("bb_led", LED, exp_led);
            if (k % 20 == 0) chk_disp(FLIP, exp_led);
        end
        START = 1'b0;
        @(negedge CLK);
        chk("bb_idle", BUSY, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bitserial_subtractor.md
BITSERIAL_SUBTRACTOR -- requirements
Module: bitserial_subtractor

Interface
REQ-001 SHALL have port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port SW  input  8  operands: SW[3:0] = minuend A, SW[7:4] = subtrahend B, both unsigned.
REQ-004 SHALL have port BIN  input  1  borrow-in.
REQ-005 SHALL have port START  input  1  level-sampled request to begin a subtraction.
REQ-006 SHALL have port FLIP  input  1  display select: 0 = difference, 1 = borrow-out.
REQ-007 SHALL have port LED  output  5  LED[3:0] = last difference D, LED[4] = last borrow-out BOUT.
REQ-008 SHALL have port BUSY  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse when a new result is loaded.
REQ-010 SHALL have ports SLED0..SLED4  output  7 each  active-low seven-segment codes, bit order {a,b,c,d,e,f,g}.

Function
REQ-011 SHALL implement FSM states IDLE and SHIFT, plus a 2-bit bit counter CNT.
REQ-012 In IDLE with START=1 at a rising edge, the block SHALL load A, B and BIN into internal shift/borrow registers, clear CNT, and enter SHIFT.
REQ-013 In SHIFT, each rising edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-014 SHALL shift each d into a 4-bit difference shift register, shift the A/B registers right by one, and increment CNT.
REQ-015 On the edge that processes bit 3 (CNT=3), the block SHALL load LED[3:0] = D and LED[4] = final borrow, set DONE=1 for exactly the following cycle, and return to IDLE.
REQ-016 Latency SHALL be: START sampled at edge N; bits 0..3 processed at edges N+1..N+4; result and DONE visible after edge N+4.
REQ-017 Result SHALL equal (A - B - BIN) mod 16, and BOUT SHALL be 1 iff A < B + BIN.
REQ-018 BUSY SHALL be 1 exactly while the state is SHIFT.
REQ-019 START while BUSY=1 SHALL be ignored.
REQ-020 Changes on SW or BIN after the START edge SHALL NOT affect the running operation.
REQ-021 With START held high, the block SHALL restart at edge N+5, so back-to-back operations have a 5-cycle period.
REQ-022 LED SHALL hold its last result until the next completion.
REQ-023 Displays SHALL be combinational from the result registers and FLIP.
REQ-024 Digit encodings: 0 = 0000001, 1 = 1001111, blank = 1111111.
REQ-025 FLIP=0: SLED0..SLED3 SHALL show D[0]..D[3] as 0/1 digits, and SLED4 SHALL show 'd' = 1000010.
REQ-026 FLIP=1: SLED0 SHALL show BOUT as a 0/1 digit, SLED1..SLED3 SHALL be blank, and SLED4 SHALL show 'b' = 1100000.
REQ-027 A FLIP change SHALL affect the displays only, never the FSM or the result registers.

Reset
REQ-028 RSTN=0 SHALL immediately force state IDLE, CNT=0, all shift registers 0, LED=00000, BUSY=0, DONE=0, independent of CLK.
REQ-029 After reset, displays SHALL show the zero result: FLIP=0 gives SLED0..3 = 0000001 and SLED4 = 1000010; FLIP=1 gives SLED0 = 0000001, SLED1..3 blank, SLED4 = 1100000.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no DONE pulse and LED cleared to 0.
REQ-031 The first START SHALL be honoured on the first rising edge after RSTN deasserts.

Verification
REQ-032 A=9, B=3, BIN=0, START pulse -> BUSY high 4 cycles, DONE pulse after edge N+4, LED=00110 (D=6, BOUT=0).
REQ-033 A=3, B=9, BIN=0 -> LED=11010 (D=10, BOUT=1); with FLIP=1, SLED0=1001111, SLED4=1100000, SLED1..3=1111111.
REQ-034 A=0, B=0, BIN=1 -> LED=11111; with FLIP=0, SLED0..3 all 1001111.
REQ-035 START pulsed again at edge N+2 and SW changed at edge N+1 -> result still 9-3=6, exactly one DONE pulse.
REQ-036 RSTN low at edge N+2 -> BUSY=0 and LED=0 immediately, no DONE; a new START after release completes normally.
REQ-037 START held high, random A/B/BIN for 200 operations -> DONE every 5 cycles, each result matching (A-B-BIN) mod 16 and its borrow.
